// File: rtl/glm_dot_pack.sv
// glm_dot_pack: drains 32-bit dot results, packs them into 512-bit lines and
// writes each line either to MEM_result (at offset + line index) or FIFO_result.
module glm_dot_pack #(
    parameter int unsigned VALUES_PER_LINE = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_start,
    output logic             op_done,
    input  logic [4:0][31:0] regs,
    // FIFO_dot read side
    output logic             FIFO_dot_re,
    input  logic             FIFO_dot_rvalid,
    input  logic [31:0]      FIFO_dot_rdata,
    input  logic             FIFO_dot_empty,
    // MEM_result write side
    output logic             MEM_result_we,
    output logic [15:0]      MEM_result_waddr,
    output logic [511:0]     MEM_result_wdata,
    // FIFO_result write side
    output logic             FIFO_result_we,
    output logic [511:0]     FIFO_result_wdata,
    input  logic             FIFO_result_almostfull
);

    localparam int unsigned LANE_W = $clog2(VALUES_PER_LINE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         num_q, num_d;
    logic                to_fifo_q, to_fifo_d;
    logic [15:0]         offset_q, offset_d;
    logic [15:0]         req_q, req_d;
    logic [15:0]         rcv_q, rcv_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [15:0]         line_idx_q, line_idx_d;
    logic [511:0]        line_q, line_d;
    logic                mem_we_q, mem_we_d;
    logic [15:0]         mem_waddr_q, mem_waddr_d;
    logic [511:0]        mem_wdata_q, mem_wdata_d;
    logic                fifo_we_q, fifo_we_d;
    logic [511:0]        fifo_wdata_q, fifo_wdata_d;
    logic [511:0]        line_ins;
    logic                unused_regs;

    assign unused_regs = ^{regs[2:0], regs[3][31:17], regs[4][31:16]};

    assign MEM_result_we     = mem_we_q;
    assign MEM_result_waddr  = mem_waddr_q;
    assign MEM_result_wdata  = mem_wdata_q;
    assign FIFO_result_we    = fifo_we_q;
    assign FIFO_result_wdata = fifo_wdata_q;

    // State register and datapath registers; reset aborts any op with no write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            to_fifo_q    <= 1'b0;
            offset_q     <= '0;
            req_q        <= '0;
            rcv_q        <= '0;
            lane_q       <= '0;
            line_idx_q   <= '0;
            line_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            fifo_we_q    <= 1'b0;
            fifo_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            to_fifo_q    <= to_fifo_d;
            offset_q     <= offset_d;
            req_q        <= req_d;
            rcv_q        <= rcv_d;
            lane_q       <= lane_d;
            line_idx_q   <= line_idx_d;
            line_q       <= line_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            fifo_we_q    <= fifo_we_d;
            fifo_wdata_q <= fifo_wdata_d;
        end
    end

    // Next-state, read requests, lane packing and line emit decisions.
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        to_fifo_d    = to_fifo_q;
        offset_d     = offset_q;
        req_d        = req_q;
        rcv_d        = rcv_q;
        lane_d       = lane_q;
        line_idx_d   = line_idx_q;
        line_d       = line_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        fifo_we_d    = 1'b0;
        fifo_wdata_d = fifo_wdata_q;
        line_ins     = line_q;
        FIFO_dot_re  = 1'b0;
        op_done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_start) begin
                    num_d      = regs[3][15:0];
                    to_fifo_d  = regs[3][16];
                    offset_d   = regs[4][15:0];
                    req_d      = '0;
                    rcv_d      = '0;
                    lane_d     = '0;
                    line_idx_d = '0;
                    line_d     = '0;
                    state_d    = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (!FIFO_dot_empty && (req_q < num_q) &&
                    !(to_fifo_q && FIFO_result_almostfull)) begin
                    FIFO_dot_re = 1'b1;
                    req_d       = req_q + 16'd1;
                end
                if (FIFO_dot_rvalid) begin
                    // The emitted line already contains the value arriving this cycle.
                    line_ins[{lane_q, 5'b0} +: 32] = FIFO_dot_rdata;
                    rcv_d = rcv_q + 16'd1;
                    if ((lane_q == LANE_W'(VALUES_PER_LINE - 1)) ||
                        (rcv_q == num_q - 16'd1)) begin
                        if (to_fifo_q) begin
                            fifo_we_d    = 1'b1;
                            fifo_wdata_d = line_ins;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_waddr_d = offset_q + line_idx_q;
                            mem_wdata_d = line_ins;
                        end
                        line_idx_d = line_idx_q + 16'd1;
                        lane_d     = '0;
                        line_d     = '0;
                    end else begin
                        line_d = line_ins;
                        lane_d = lane_q + 1'b1;
                    end
                end
                // Leaving one cycle after the last value places op_done after the final write.
                if (rcv_q == num_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                op_done = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_glm_dot_pack.sv
// tb_glm_dot_pack: random-data bench with a FIFO_dot source model and a
// line-level reference for the packed output.
module tb_glm_dot_pack;

    logic             clk;
    logic             resetn;
    logic             op_start;
    logic             op_done;
    logic [4:0][31:0] regs;
    logic             FIFO_dot_re;
    logic             FIFO_dot_rvalid;
    logic [31:0]      FIFO_dot_rdata;
    logic             FIFO_dot_empty;
    logic             MEM_result_we;
    logic [15:0]      MEM_result_waddr;
    logic [511:0]     MEM_result_wdata;
    logic             FIFO_result_we;
    logic [511:0]     FIFO_result_wdata;
    logic             FIFO_result_almostfull;

    glm_dot_pack #(.VALUES_PER_LINE(16)) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .op_start               (op_start),
        .op_done                (op_done),
        .regs                   (regs),
        .FIFO_dot_re            (FIFO_dot_re),
        .FIFO_dot_rvalid        (FIFO_dot_rvalid),
        .FIFO_dot_rdata         (FIFO_dot_rdata),
        .FIFO_dot_empty         (FIFO_dot_empty),
        .MEM_result_we          (MEM_result_we),
        .MEM_result_waddr       (MEM_result_waddr),
        .MEM_result_wdata       (MEM_result_wdata),
        .FIFO_result_we         (FIFO_result_we),
        .FIFO_result_wdata      (FIFO_result_wdata),
        .FIFO_result_almostfull (FIFO_result_almostfull)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [31:0]  src_q[$];
    logic [31:0]  exp_vals[$];
    logic [15:0]  mem_addr_q[$];
    logic [511:0] mem_data_q[$];
    logic [511:0] fifo_data_q[$];
    bit           stall_en = 1'b0;
    int           af_from  = 0;
    int           af_len   = 0;
    int           start_cyc = 0;
    int           re_cnt, rv_cnt, done_cnt, done_cyc, last_we_cyc, af_viol;
    bit           re_seen = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO_dot source: re seen in cycle t returns data in cycle t+1.
    initial begin
        FIFO_dot_rvalid        = 1'b0;
        FIFO_dot_rdata         = '0;
        FIFO_dot_empty         = 1'b1;
        FIFO_result_almostfull = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (resetn && re_seen && src_q.size() > 0) begin
                FIFO_dot_rvalid = 1'b1;
                FIFO_dot_rdata  = src_q.pop_front();
            end else begin
                FIFO_dot_rvalid = 1'b0;
                FIFO_dot_rdata  = $urandom();
            end
            FIFO_dot_empty = (src_q.size() == 0) || (stall_en && $urandom_range(0, 2) == 0);
            FIFO_result_almostfull = (af_len > 0) && (cyc - start_cyc >= af_from) &&
                                     (cyc - start_cyc < af_from + af_len);
        end
    end

    // Output monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        re_seen = FIFO_dot_re;
        if (FIFO_dot_re) re_cnt++;
        if (FIFO_dot_re && FIFO_result_almostfull && regs[3][16]) af_viol++;
        if (FIFO_dot_rvalid) rv_cnt++;
        if (MEM_result_we) begin
            mem_addr_q.push_back(MEM_result_waddr);
            mem_data_q.push_back(MEM_result_wdata);
            last_we_cyc = cyc;
        end
        if (FIFO_result_we) begin
            fifo_data_q.push_back(FIFO_result_wdata);
            last_we_cyc = cyc;
        end
        if (op_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic start_op(input int num, input logic [15:0] off, input bit tf, input bit seq_vals);
        logic [31:0] v;
        src_q.delete();
        exp_vals.delete();
        for (int i = 0; i < num; i++) begin
            v = seq_vals ? 32'(i + 1) : $urandom();
            src_q.push_back(v);
            exp_vals.push_back(v);
        end
        mem_addr_q.delete();
        mem_data_q.delete();
        fifo_data_q.delete();
        re_cnt = 0; rv_cnt = 0; done_cnt = 0; done_cyc = 0; last_we_cyc = 0; af_viol = 0;
        regs = '0;
        regs[3] = {15'd0, tf, 16'(num)};
        regs[4] = {16'd0, off};
        @(negedge clk);
        op_start  = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        op_start = 1'b0;
    endtask

    task automatic finish_op(input int num, input logic [15:0] off, input bit tf, input string name);
        int budget;
        int nlines;
        logic [511:0] line;
        int idx;
        budget = 0;
        while (done_cnt == 0 && budget < 600) begin
            @(negedge clk);
            #2;
            budget++;
        end
        repeat (4) @(negedge clk);
        #2;
        nlines = (num + 15) / 16;
        check($sformatf("%s_done_cnt", name), done_cnt, 1);
        check($sformatf("%s_re_cnt", name), re_cnt, num);
        check($sformatf("%s_af_viol", name), af_viol, 0);
        check($sformatf("%s_mem_writes", name), mem_data_q.size(), tf ? 0 : nlines);
        check($sformatf("%s_fifo_writes", name), fifo_data_q.size(), tf ? nlines : 0);
        for (int k = 0; k < nlines; k++) begin
            line = '0;
            for (int j = 0; j < 16; j++) begin
                idx = 16 * k + j;
                if (idx < num) line[32*j +: 32] = exp_vals[idx];
            end
            if (tf) begin
                if (k < fifo_data_q.size())
                    check($sformatf("%s_fifo_line%0d", name, k), fifo_data_q[k], line);
            end else if (k < mem_data_q.size()) begin
                check($sformatf("%s_mem_line%0d", name, k), mem_data_q[k], line);
                check($sformatf("%s_mem_addr%0d", name, k), mem_addr_q[k], 16'(off + 16'(k)));
            end
        end
        if (num == 0)
            check($sformatf("%s_done_after_start", name), done_cyc - start_cyc, 2);
        else
            check($sformatf("%s_done_after_we", name), done_cyc - last_we_cyc, 1);
    endtask

    task automatic check_outputs_zero(input string name);
        check($sformatf("%s_re", name), FIFO_dot_re, 0);
        check($sformatf("%s_mem_we", name), MEM_result_we, 0);
        check($sformatf("%s_fifo_we", name), FIFO_result_we, 0);
        check($sformatf("%s_op_done", name), op_done, 0);
        check($sformatf("%s_waddr", name), MEM_result_waddr, 0);
        check($sformatf("%s_mem_wdata", name), MEM_result_wdata, 0);
        check($sformatf("%s_fifo_wdata", name), FIFO_result_wdata, 0);
    endtask

    initial begin
        int budget;
        int num;
        bit tf;
        logic [15:0] off;
        resetn   = 1'b1;
        op_start = 1'b0;
        regs     = '0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // One full line to MEM, values 1..16 back-to-back.
        start_op(16, 16'h0100, 1'b0, 1'b1);
        finish_op(16, 16'h0100, 1'b0, "n16_mem");

        // Address wraps from 0xFFFF to 0x0000, partial second line.
        start_op(20, 16'hFFFF, 1'b0, 1'b0);
        finish_op(20, 16'hFFFF, 1'b0, "n20_wrap");

        // FIFO mode with almostfull held for 10 cycles mid-stream.
        af_from = 8; af_len = 10;
        start_op(33, 16'h0000, 1'b1, 1'b0);
        finish_op(33, 16'h0000, 1'b1, "n33_fifo_af");
        af_len = 0;

        // Empty instruction.
        start_op(0, 16'h0010, 1'b0, 1'b0);
        finish_op(0, 16'h0010, 1'b0, "n0");

        // Random empty stalls plus a stray op_start during COLLECT.
        stall_en = 1'b1;
        start_op(16, 16'h0200, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        finish_op(16, 16'h0200, 1'b0, "n16_stall");
        stall_en = 1'b0;

        // Reset after 7 of 16 values, then a clean run.
        start_op(16, 16'h0040, 1'b0, 1'b0);
        budget = 0;
        while (rv_cnt < 7 && budget < 200) begin
            @(negedge clk);
            #2;
            budget++;
        end
        check("midreset_rv_reached", rv_cnt, 7);
        resetn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        #2;
        check("midreset_no_write", mem_data_q.size() + fifo_data_q.size(), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        start_op(16, 16'h0300, 1'b0, 1'b0);
        finish_op(16, 16'h0300, 1'b0, "after_reset");

        // Random instructions.
        for (int t = 0; t < 5; t++) begin
            num      = $urandom_range(1, 50);
            tf       = 1'($urandom_range(0, 1));
            off      = 16'($urandom());
            stall_en = 1'($urandom_range(0, 1));
            af_from  = $urandom_range(2, 20);
            af_len   = tf ? 10 : 0;
            start_op(num, off, tf, 1'b0);
            finish_op(num, off, tf, $sformatf("rand%0d", t));
        end
        stall_en = 1'b0;
        af_len   = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
